// File: rtl/ap_ctrl_sequencer.sv
// Run sequencer for an ap_ctrl_chain kernel: issues cfg_count starts, tracks completions, drains on abort.
// Optional watchdog (ERR state, timeout_err_o) is built in when AP_CTRL_SEQ_WATCHDOG_EN is defined.
module ap_ctrl_sequencer #(
   parameter int CNT_W    = 16,
   parameter int CYC_W    = 32,
   parameter int WDOG_CYC = 1000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             go_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] cfg_count_i,
   output logic             ap_start_o,
   input  logic             ap_ready_i,
   input  logic             ap_done_i,
   output logic             ap_continue_o,
   output logic             busy_o,
   output logic             finish_o,
   output logic [CNT_W-1:0] issued_cnt_o,
   output logic [CNT_W-1:0] done_cnt_o,
   output logic [CYC_W-1:0] run_cycles_o,
   output logic             proto_err_o,
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
   output logic             timeout_err_o,
`endif
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] done_q, done_d;
   logic [CYC_W-1:0] cycles_q, cycles_d;
   logic             perr_q, perr_d;
   logic             ap_start_q, ap_start_d;
   logic             active, hs;
   logic [CNT_W-1:0] issued_now;

`ifdef AP_CTRL_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC + 1);
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            tout_q, tout_d;
`endif

   // ap_start_q is only ever high in RUN, so hs already implies RUN.
   assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign hs         = ap_start_q && ap_ready_i;
   assign issued_now = hs ? issued_q + 1'b1 : issued_q;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      issued_d = issued_now;
      done_d   = done_q;
      cycles_d = cycles_q;
      perr_d   = perr_q;
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
      wdog_d   = wdog_q;
      tout_d   = tout_q;
`endif

      if (active) begin
         if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
         // A completion may pair with a start accepted in this same cycle.
         if (ap_done_i) begin
            if (done_q < issued_now) done_d = done_q + 1'b1;
            else                     perr_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (go_i) begin
               target_d = cfg_count_i;
               issued_d = '0;
               done_d   = '0;
               cycles_d = '0;
               perr_d   = 1'b0;
               state_d  = (cfg_count_i != '0) ? S_RUN : S_DONE;
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
               wdog_d   = '0;
               tout_d   = 1'b0;
`endif
            end
         end
         S_RUN:   if (issued_now == target_q || abort_i) state_d = S_DRAIN;
         S_DRAIN: if (done_d == issued_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

`ifdef AP_CTRL_SEQ_WATCHDOG_EN
      if (active) begin
         if (ap_ready_i || ap_done_i) begin
            wdog_d = '0;
         end else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
            state_d = S_ERR;
            tout_d  = 1'b1;
         end else begin
            wdog_d = wdog_q + 1'b1;
         end
      end
`endif

      ap_start_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         target_q   <= '0;
         issued_q   <= '0;
         done_q     <= '0;
         cycles_q   <= '0;
         perr_q     <= 1'b0;
         ap_start_q <= 1'b0;
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
         wdog_q     <= '0;
         tout_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         issued_q   <= issued_d;
         done_q     <= done_d;
         cycles_q   <= cycles_d;
         perr_q     <= perr_d;
         ap_start_q <= ap_start_d;
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
         wdog_q     <= wdog_d;
         tout_q     <= tout_d;
`endif
      end
   end

   assign ap_start_o    = ap_start_q;
   assign busy_o        = active;
   assign ap_continue_o = active;
   assign finish_o      = (state_q == S_DONE);
   assign issued_cnt_o  = issued_q;
   assign done_cnt_o    = done_q;
   assign run_cycles_o  = cycles_q;
   assign proto_err_o   = perr_q;
   assign state_o       = state_q;
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
   assign timeout_err_o = tout_q;
`endif

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Bench for ap_ctrl_sequencer: per-cycle vector table plus hand sequences for abort, saturation and reset.
// Watchdog sequence is compiled in when AP_CTRL_SEQ_WATCHDOG_EN is defined.
module tb_ap_ctrl_sequencer;

   localparam int CNT_W = 8;
   localparam int CYC_W = 4;

   logic             clk = 1'b0;
   logic             rst, go, abort, ap_ready, ap_done;
   logic [CNT_W-1:0] cfg_count;
   logic             ap_start, ap_continue, busy, finish, proto_err;
   logic [CNT_W-1:0] issued_cnt, done_cnt;
   logic [CYC_W-1:0] run_cycles;
   logic [2:0]       state;
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
   logic             timeout_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ap_ctrl_sequencer #(.CNT_W(CNT_W), .CYC_W(CYC_W), .WDOG_CYC(20)) dut (
      .clk_i(clk), .rst_i(rst), .go_i(go), .abort_i(abort), .cfg_count_i(cfg_count),
      .ap_start_o(ap_start), .ap_ready_i(ap_ready), .ap_done_i(ap_done),
      .ap_continue_o(ap_continue), .busy_o(busy), .finish_o(finish),
      .issued_cnt_o(issued_cnt), .done_cnt_o(done_cnt), .run_cycles_o(run_cycles),
      .proto_err_o(proto_err),
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
      .timeout_err_o(timeout_err),
`endif
      .state_o(state)
   );

   typedef struct {
      logic             rst, go, abort;
      logic [CNT_W-1:0] cfg;
      logic             rdy, dn;
      logic             st, busy, fin;
      logic [CNT_W-1:0] iss, dnc;
      logic             perr;
      logic [CYC_W-1:0] rc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic g, logic a, int c, logic rd, logic d,
                               logic st, logic b, logic f, int iss, int dnc, logic pe, int rc);
      vec_t v;
      v.rst = r; v.go = g; v.abort = a; v.cfg = CNT_W'(c); v.rdy = rd; v.dn = d;
      v.st = st; v.busy = b; v.fin = f; v.iss = CNT_W'(iss); v.dnc = CNT_W'(dnc);
      v.perr = pe; v.rc = CYC_W'(rc);
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the edge that consumed them.
   task automatic step(logic r, logic g, logic a, int c, logic rd, logic d);
      rst = r; go = g; abort = a; cfg_count = CNT_W'(c); ap_ready = rd; ap_done = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; abort = 1'b0; cfg_count = '0; ap_ready = 1'b0; ap_done = 1'b0;

      //              rst go ab cfg rdy dn | st bsy fin iss dn perr rc
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3, 0, 0,   1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,   1, 1, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,   1, 1, 0, 2, 0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,   0, 1, 0, 3, 0, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 3, 0, 0, 4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 3, 0, 0, 5));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 1, 0, 3, 1, 0, 6));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 1, 0, 3, 2, 0, 7));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 1, 3, 3, 0, 8));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 3, 0, 8));
      // zero-length run
      tbl.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      // stray ap_done sets proto_err; same-cycle ready+done
      tbl.push_back(mk(0, 1, 0, 2, 0, 0,   1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,   1, 1, 0, 1, 0, 1, 2));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 1, 0, 2, 1, 1, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 1, 2, 2, 1, 4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 2, 1, 4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 2, 2, 1, 4));
      // go clears proto_err; go during RUN ignored
      tbl.push_back(mk(0, 1, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 7, 0, 0,   1, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 1, 0, 1, 1, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 3));
      // abort with nothing outstanding: one DRAIN cycle
      tbl.push_back(mk(0, 1, 0, 5, 0, 0,   1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2));
      // handshake in the abort cycle still counts
      tbl.push_back(mk(0, 1, 0, 5, 0, 0,   1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0,   0, 1, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 1, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 2));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].go, tbl[i].abort, int'(tbl[i].cfg), tbl[i].rdy, tbl[i].dn);
         chk($sformatf("v%0d ap_start", i),  ap_start,    tbl[i].st);
         chk($sformatf("v%0d busy", i),      busy,        tbl[i].busy);
         chk($sformatf("v%0d continue", i),  ap_continue, tbl[i].busy);
         chk($sformatf("v%0d finish", i),    finish,      tbl[i].fin);
         chk($sformatf("v%0d issued", i),    issued_cnt,  tbl[i].iss);
         chk($sformatf("v%0d done", i),      done_cnt,    tbl[i].dnc);
         chk($sformatf("v%0d proto_err", i), proto_err,   tbl[i].perr);
         chk($sformatf("v%0d run_cycles", i), run_cycles, tbl[i].rc);
         if (i == 0) chk("reset state", state, 3'd0);
      end

      // Abort after 4th handshake with 2 outstanding
      step(0, 1, 0, 10, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 0);
      chk("abort pre issued", issued_cnt, 4);
      chk("abort pre done", done_cnt, 2);
      step(0, 0, 1, 0, 0, 0);
      chk("abort ap_start low", ap_start, 0);
      chk("abort draining", busy, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("abort no early finish", finish, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("abort finish", finish, 1);
      chk("abort issued", issued_cnt, 4);
      chk("abort done", done_cnt, 4);
      step(0, 0, 0, 0, 0, 0);
      chk("abort finish single", finish, 0);

      // run_cycles saturates at all-ones while start is held
      step(0, 1, 0, 1, 0, 0);
      for (int k = 1; k <= 17; k++) begin
         step(0, 0, 0, 0, 0, 0);
         if (k == 14) chk("sat rc 14", run_cycles, 14);
         if (k == 15) chk("sat rc 15", run_cycles, 15);
      end
      chk("sat rc held", run_cycles, 15);
      chk("sat start held", ap_start, 1);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("sat finish", finish, 1);
      step(0, 0, 0, 0, 0, 0);

      // Reset mid-DRAIN with 2 outstanding
      step(0, 1, 0, 3, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("rst pre busy", busy, 1);
      chk("rst pre outstanding", issued_cnt - done_cnt, 2);
      step(1, 0, 0, 0, 0, 0);
      chk("rst state", state, 3'd0);
      chk("rst busy", busy, 0);
      chk("rst continue", ap_continue, 0);
      chk("rst start", ap_start, 0);
      chk("rst issued", issued_cnt, 0);
      chk("rst done", done_cnt, 0);
      chk("rst run_cycles", run_cycles, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("rst no finish", finish, 0);
      chk("rst done ignored", done_cnt, 0);
      chk("rst no proto_err", proto_err, 0);

`ifdef AP_CTRL_SEQ_WATCHDOG_EN
      step(0, 1, 0, 2, 0, 0);
      for (int k = 1; k <= 19; k++) step(0, 0, 0, 0, 0, 0);
      chk("wdog not yet", timeout_err, 0);
      chk("wdog start held", ap_start, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("wdog timeout", timeout_err, 1);
      chk("wdog start low", ap_start, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("wdog finish", finish, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("wdog idle", state, 3'd0);
      chk("wdog sticky", timeout_err, 1);
      step(0, 1, 0, 0, 0, 0);
      chk("wdog cleared by go", timeout_err, 0);
      step(0, 0, 0, 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
